// File: rtl/icache_fill_ctrl_pkg.sv
// Shared constants, state encoding and address helper for the I-cache fill controller.
package icache_fill_ctrl_pkg;

  localparam int unsigned WORDS_PER_BLOCK   = 8;
  localparam int unsigned ADDR_W            = 16;
  localparam int unsigned DATA_W            = 16;
  localparam int unsigned MEM_LATENCY       = 4;
  localparam int unsigned BLOCK_OFFSET_BITS = 4;
  localparam int unsigned ISSUE_W           = 4;
  localparam int unsigned RECV_W            = 3;

  // Clears the byte-offset-within-block bits of an address.
  localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'((1 << BLOCK_OFFSET_BITS) - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

  // Byte offset of a 16-bit word index inside a block.
  function automatic logic [ADDR_W-1:0] word_offset(input logic [ISSUE_W-1:0] idx);
    return ADDR_W'(idx) << 1;
  endfunction

endpackage

// File: rtl/icache_fill_ctrl_if.sv
// Miss, memory and cache-write signals between the fill controller and its neighbours.
interface icache_fill_ctrl_if;
  import icache_fill_ctrl_pkg::*;

  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_data_valid;
  logic              mem_enable;
  logic [ADDR_W-1:0] mem_address;
  logic              fsm_busy;
  logic              write_data_array;
  logic              write_tag_array;
  logic [ADDR_W-1:0] cache_word_addr;
  logic [DATA_W-1:0] cache_data;
  logic              fill_done;

  // Controller side.
  modport master (
    input  miss_detected, miss_address, mem_data_in, mem_data_valid,
    output mem_enable, mem_address, fsm_busy, write_data_array, write_tag_array,
           cache_word_addr, cache_data, fill_done
  );

  // Fetch stage / memory / cache side.
  modport slave (
    output miss_detected, miss_address, mem_data_in, mem_data_valid,
    input  mem_enable, mem_address, fsm_busy, write_data_array, write_tag_array,
           cache_word_addr, cache_data, fill_done
  );

endinterface

// File: rtl/icache_fill_ctrl_fill_word_counter.sv
// Up-counter with async reset, synchronous clear, enable and terminal-count flag.
module fill_word_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned TERMINAL = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc_c
);

  // Clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc_c = (count == WIDTH'(TERMINAL));

endmodule

// File: rtl/icache_fill_ctrl.sv
// Freezes fetch on an I-cache miss and streams one 8-word block from memory into the cache.
module icache_fill_ctrl
  import icache_fill_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  icache_fill_ctrl_if.master bus
);

  fill_state_e        state;
  logic [ADDR_W-1:0]  base;
  logic               fill_done_q;
  logic [ISSUE_W-1:0] issue_cnt;
  logic               issue_tc_c;
  logic [RECV_W-1:0]  recv_cnt;
  logic               recv_tc_c;
  logic               start_c;
  logic               issue_en_c;
  logic               recv_en_c;
  logic               last_word_c;

  // Fill sequencing qualifiers derived from the current state.
  always_comb begin
    start_c     = (state == ST_IDLE) && bus.miss_detected;
    issue_en_c  = (state == ST_FILL) && !issue_tc_c;
    recv_en_c   = (state == ST_FILL) && bus.mem_data_valid;
    last_word_c = recv_en_c && recv_tc_c;
  end

  // Counts read requests issued; stops at a full block.
  fill_word_counter #(
    .WIDTH    (ISSUE_W),
    .TERMINAL (WORDS_PER_BLOCK)
  ) u_issue_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr   (start_c),
    .en    (issue_en_c),
    .count (issue_cnt),
    .tc_c  (issue_tc_c)
  );

  // Counts words returned by memory; the last word flags the tag write.
  fill_word_counter #(
    .WIDTH    (RECV_W),
    .TERMINAL (WORDS_PER_BLOCK - 1)
  ) u_recv_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr   (start_c),
    .en    (recv_en_c),
    .count (recv_cnt),
    .tc_c  (recv_tc_c)
  );

  // State, block base and the done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      base        <= '0;
      fill_done_q <= 1'b0;
    end else begin
      fill_done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_c) begin
            base  <= bus.miss_address & BLOCK_MASK;
            state <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (last_word_c) begin
            fill_done_q <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Strobes and addresses; busy follows the miss directly so fetch freezes in the miss cycle.
  always_comb begin
    bus.fsm_busy         = 1'b0;
    bus.mem_enable       = 1'b0;
    bus.mem_address      = '0;
    bus.write_data_array = 1'b0;
    bus.write_tag_array  = 1'b0;
    bus.cache_word_addr  = '0;
    case (state)
      ST_IDLE: bus.fsm_busy = bus.miss_detected;
      ST_FILL: begin
        bus.fsm_busy         = 1'b1;
        bus.mem_enable       = issue_en_c;
        bus.write_data_array = recv_en_c;
        bus.write_tag_array  = last_word_c;
        if (issue_en_c) begin
          bus.mem_address = base + word_offset(issue_cnt);
        end
        if (recv_en_c) begin
          bus.cache_word_addr = base + word_offset(ISSUE_W'(recv_cnt));
        end
      end
      default: ;
    endcase
  end

  assign bus.cache_data = bus.mem_data_in;
  assign bus.fill_done  = fill_done_q;

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Randomized bench for icache_fill_ctrl against a transaction-level fill model.
module tb_icache_fill_ctrl;
  import icache_fill_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;

  icache_fill_ctrl_if bus();

  icache_fill_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Outstanding memory reads: address and the cycle its data comes back.
  logic [15:0] pend_addr[$];
  int          pend_due[$];
  int          last_due;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC35A;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_quiet(input string tag, input bit with_addr);
    check_eq({tag, "_busy"},      32'(bus.fsm_busy),         32'(0));
    check_eq({tag, "_mem_en"},    32'(bus.mem_enable),       32'(0));
    check_eq({tag, "_wr_data"},   32'(bus.write_data_array), 32'(0));
    check_eq({tag, "_wr_tag"},    32'(bus.write_tag_array),  32'(0));
    check_eq({tag, "_fill_done"}, 32'(bus.fill_done),        32'(0));
    if (with_addr) begin
      check_eq({tag, "_mem_addr"},  32'(bus.mem_address),     32'(0));
      check_eq({tag, "_cache_addr"}, 32'(bus.cache_word_addr), 32'(0));
    end
  endtask

  task automatic idle_cycles(input int n, input bit rand_valid);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1; cyc++;
      bus.miss_detected  = 1'b0;
      bus.miss_address   = 16'($urandom);
      bus.mem_data_valid = rand_valid ? 1'($urandom) : 1'b0;
      bus.mem_data_in    = 16'($urandom);
      @(negedge clk);
      check_quiet("idle", 1'b0);
    end
  endtask

  // One miss-to-done transaction. Miss is driven in relative cycle 0; requests are expected in
  // cycles 1..8, the i-th valid writes word i, the 8th also writes the tag, done follows.
  task automatic run_fill(input logic [15:0] addr, input int lat, input int max_gap,
                          input bit toggle_miss, input int abort_k, output int tag_k_o);
    logic [15:0] base;
    logic [15:0] raddr;
    logic [15:0] exp_addr;
    int          n_wr;
    int          tag_k;
    bit          valid;
    bit          done_seen;
    int          due;
    base      = addr & 16'hFFF0;
    n_wr      = 0;
    tag_k     = -1;
    done_seen = 1'b0;
    raddr     = '0;
    pend_addr.delete();
    pend_due.delete();
    last_due  = 0;
    for (int k = 0; k < 64 && !done_seen; k++) begin
      @(posedge clk); #1; cyc++;
      valid = 1'b0;
      if (pend_due.size() > 0 && pend_due[0] <= k) begin
        valid = 1'b1;
        raddr = pend_addr.pop_front();
        void'(pend_due.pop_front());
      end
      bus.mem_data_valid = valid;
      bus.mem_data_in    = valid ? mem_word(raddr) : 16'($urandom);
      if (k == 0) begin
        bus.miss_detected = 1'b1;
        bus.miss_address  = addr;
      end else if (toggle_miss && k <= 4) begin
        bus.miss_detected = 1'($urandom);
        bus.miss_address  = 16'($urandom);
      end else begin
        bus.miss_detected = 1'b0;
      end

      if (abort_k > 0 && k == abort_k) begin
        rst = 1'b0;
        @(negedge clk);
        check_quiet("abort", 1'b1);
        for (int j = 0; j < 5; j++) begin
          @(posedge clk); #1; cyc++;
          rst                = 1'b1;
          bus.miss_detected  = 1'b0;
          bus.mem_data_valid = 1'b1;
          bus.mem_data_in    = 16'($urandom);
          @(negedge clk);
          check_quiet("post_abort", 1'b0);
        end
        bus.mem_data_valid = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        tag_k_o = -1;
        return;
      end

      @(negedge clk);
      check_eq("busy", 32'(bus.fsm_busy), 32'(!(tag_k >= 0 && k == tag_k + 1)));
      check_eq("mem_en", 32'(bus.mem_enable), 32'(k >= 1 && k <= 8));
      if (k >= 1 && k <= 8) begin
        exp_addr = base + 16'(2 * (k - 1));
        check_eq("mem_addr", 32'(bus.mem_address), 32'(exp_addr));
        due = k + lat + ((max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend_addr.push_back(exp_addr);
        pend_due.push_back(due);
      end
      check_eq("wr_data", 32'(bus.write_data_array), 32'(valid));
      if (valid) begin
        exp_addr = base + 16'(2 * n_wr);
        check_eq("cache_addr", 32'(bus.cache_word_addr), 32'(exp_addr));
        check_eq("cache_data", 32'(bus.cache_data), 32'(mem_word(exp_addr)));
        check_eq("wr_tag", 32'(bus.write_tag_array), 32'(n_wr == 7));
        if (n_wr == 7) tag_k = k;
        n_wr++;
      end else begin
        check_eq("wr_tag", 32'(bus.write_tag_array), 32'(0));
      end
      check_eq("fill_done", 32'(bus.fill_done), 32'(tag_k >= 0 && k == tag_k + 1));
      if (tag_k >= 0 && k == tag_k + 1) done_seen = 1'b1;
    end
    check_eq("fill_words", 32'(n_wr), 32'(8));
    check_eq("fill_reached_done", 32'(done_seen), 32'(1));
    tag_k_o = tag_k;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int tk;
    rst                = 1'b0;
    bus.miss_detected  = 1'b0;
    bus.miss_address   = '0;
    bus.mem_data_valid = 1'b0;
    bus.mem_data_in    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset", 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    idle_cycles(3, 1'b1);

    // Reset while idle.
    @(posedge clk); #1; cyc++;
    rst = 1'b0;
    @(negedge clk);
    check_quiet("reset_idle", 1'b1);
    @(posedge clk); #1; cyc++;
    rst = 1'b1;
    idle_cycles(2, 1'b1);

    // Nominal fill: tag write 12 cycles after the miss.
    run_fill(16'h1236, int'(MEM_LATENCY), 0, 1'b0, 0, tk);
    check_eq("nominal_tag_cycle", 32'(tk), 32'(12));
    idle_cycles(2, 1'b0);

    // Random addresses, latencies and valid gaps.
    for (int i = 0; i < 6; i++) begin
      run_fill(16'($urandom), int'($urandom_range(5, 1)), 3, 1'b0, 0, tk);
      idle_cycles(int'($urandom_range(2, 0)), 1'b0);
    end

    // Misses during the fill are ignored.
    run_fill(16'h1236, int'(MEM_LATENCY), 2, 1'b1, 0, tk);
    idle_cycles(1, 1'b0);

    // Reset in cycle 7 of a fill aborts it; later valids are ignored.
    run_fill(16'h1236, int'(MEM_LATENCY), 0, 1'b0, 7, tk);
    idle_cycles(2, 1'b1);

    // Back-to-back fills at both ends of the address space.
    run_fill(16'h0000, int'(MEM_LATENCY), 0, 1'b0, 0, tk);
    run_fill(16'hFFFE, 2, 1, 1'b0, 0, tk);
    idle_cycles(1, 1'b0);

    // Single-cycle memory.
    run_fill(16'($urandom), 1, 0, 1'b0, 0, tk);
    check_eq("fast_tag_cycle", 32'(tk), 32'(9));
    idle_cycles(3, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
